// File: rtl/fb_write_drain.sv
// ============================================================================
// Module      : fb_write_drain
// Description : Drains {hpos, vpos, rgb} pixel writes from the write FIFO and
//               issues one row-major framebuffer write per visible pixel.
//               Optional FB_DRAIN_PIPELINE_EN: pop the next entry on the
//               granting edge for 2 cycles/pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_drain #(
  parameter int RESOLUTION_H = 1280,
  parameter int RESOLUTION_V = 960,
  parameter int H_FRONT      = 80,
  parameter int H_SYNC       = 136,
  parameter int H_BACK       = 216,
  parameter int V_BOTTOM     = 1,
  parameter int V_SYNC       = 3,
  parameter int V_TOP        = 30,
  parameter int HPOS_WIDTH   = $clog2(RESOLUTION_H + H_FRONT + H_SYNC + H_BACK),
  parameter int VPOS_WIDTH   = $clog2(RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP),
  parameter int ADDR_WIDTH   = $clog2(RESOLUTION_H * RESOLUTION_V)
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [HPOS_WIDTH-1:0] fifo_hpos,
  input  logic [VPOS_WIDTH-1:0] fifo_vpos,
  input  logic [2:0]            fifo_rgb,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_wdata,
  output logic                  busy
);

  localparam int PROD_WIDTH = VPOS_WIDTH + HPOS_WIDTH + 1;
  localparam logic [HPOS_WIDTH-1:0] C_H_LIMIT = HPOS_WIDTH'(RESOLUTION_H);
  localparam logic [VPOS_WIDTH-1:0] C_V_LIMIT = VPOS_WIDTH'(RESOLUTION_V);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [HPOS_WIDTH-1:0] r_hpos;
  logic [VPOS_WIDTH-1:0] r_vpos;
  logic [2:0]            r_rgb;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_in_range;

  // Product formed at full width, then truncated to the framebuffer address.
  assign w_addr     = ADDR_WIDTH'(PROD_WIDTH'(r_vpos) * PROD_WIDTH'(RESOLUTION_H)
                                  + PROD_WIDTH'(r_hpos));
  assign w_in_range = (r_hpos < C_H_LIMIT) && (r_vpos < C_V_LIMIT);
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_hpos    <= '0;
      r_vpos    <= '0;
      r_rgb     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (fifo_pop) begin
        r_hpos <= fifo_hpos;
        r_vpos <= fifo_vpos;
        r_rgb  <= fifo_rgb;
      end
      if (r_state == CALC) begin
        mem_addr  <= w_addr;
        mem_wdata <= r_rgb;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    fifo_pop     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by reset so the pop strobe is low while reset is held.
        if (rst && !fifo_empty) begin
          fifo_pop     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        w_state_next = w_in_range ? REQ : IDLE;
      end
      REQ: begin
        mem_req = 1'b1;
        mem_we  = mem_gnt;
        if (mem_gnt) begin
          w_state_next = IDLE;
`ifdef FB_DRAIN_PIPELINE_EN
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            w_state_next = CALC;
          end
`endif
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
